// File: rtl/io_out_uart_tx.sv
// io_out_uart_tx: watches a 32-bit io_out word and, whenever it changes while
// capture_en is high, queues the new value and sends it LSB byte first as four
// back-to-back UART frames (8N1).
// Defining IO_OUT_UART_PARITY_EN adds an even parity bit after the data bits
// of every byte (8E1).
module io_out_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] io_out_in,
  input  logic        capture_en,
  output logic        tx,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BitLast = 16'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] FifoFull = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  logic [31:0]   prev_q;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          overflow_q;

  state_e        state_q, state_d;
  logic [15:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [31:0]   shift_q, shift_d;
  logic          tx_q, tx_d;
`ifdef IO_OUT_UART_PARITY_EN
  logic          parity_q, parity_d;
`endif

  logic fifo_empty, fifo_full, push_req, push, pop, bit_done;
  logic [31:0] fifo_rdata;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FifoFull);
  assign fifo_rdata = mem_q[rd_ptr_q];
  assign push_req   = capture_en && (io_out_in != prev_q);
  // A full FIFO still accepts a push when a word leaves in the same cycle.
  assign push       = push_req && (!fifo_full || pop);
  assign bit_done   = (clk_cnt_q == BitLast);

  // Change detector, FIFO storage/pointers and sticky overflow flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      prev_q <= io_out_in;
      if (push) begin
        mem_q[wr_ptr_q] <= io_out_in;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (push_req && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  // Transmitter state register; tx is registered so the line never glitches.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
`ifdef IO_OUT_UART_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
`ifdef IO_OUT_UART_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  // Next-state logic: tx_d is the line level for the bit that starts at the next edge.
  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    pop        = 1'b0;
`ifdef IO_OUT_UART_PARITY_EN
    parity_d   = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_d    = fifo_rdata;
          byte_idx_d = '0;
          clk_cnt_d  = '0;
          tx_d       = 1'b0;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[31:1]};
`ifdef IO_OUT_UART_PARITY_EN
          parity_d  = shift_q[0];
`endif
          state_d   = StData;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      StData: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef IO_OUT_UART_PARITY_EN
            tx_d    = parity_q;
            state_d = StParity;
`else
            tx_d    = 1'b1;
            state_d = StStop;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[31:1]};
`ifdef IO_OUT_UART_PARITY_EN
            parity_d  = parity_q ^ shift_q[0];
`endif
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
`ifdef IO_OUT_UART_PARITY_EN
      StParity: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          tx_d      = 1'b1;
          state_d   = StStop;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
`endif
      StStop: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          if (byte_idx_q == 2'd3) begin
            byte_idx_d = '0;
            // Chain straight into the next queued word with no idle bit.
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_d = fifo_rdata;
              tx_d    = 1'b0;
              state_d = StStart;
            end else begin
              tx_d    = 1'b1;
              state_d = StIdle;
            end
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            tx_d       = 1'b0;
            state_d    = StStart;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  assign tx       = tx_q;
  assign busy     = (state_q != StIdle) || !fifo_empty;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_io_out_uart_tx.sv
// Scoreboard bench for io_out_uart_tx: a word-level model predicts which words
// are accepted and the edge each word's start bit begins; a monitor decodes the
// serial line independently and compares against the expected queue.
module tb_io_out_uart_tx;

  localparam int unsigned C     = 4;
  localparam int unsigned DEPTH = 4;
`ifdef IO_OUT_UART_PARITY_EN
  localparam int unsigned F = 11;
`else
  localparam int unsigned F = 10;
`endif
  localparam int unsigned W = 4 * F * C;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] start;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] io_out_in = '0;
  logic        capture_en = 1'b0;
  logic        tx, busy, overflow;

  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;

  // Reference model state.
  logic [31:0] mq[$];
  exp_t        exp_q[$];
  int unsigned next_free = 0;
  logic [31:0] m_prev = '0;
  logic        m_ovf = 1'b0;
  logic        m_busy = 1'b0;
  logic        mon_active = 1'b0;

  io_out_uart_tx #(
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .io_out_in (io_out_in),
    .capture_en(capture_en),
    .tx        (tx),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle from a negedge, advance the model for the coming edge,
  // then check busy/overflow at the following negedge.
  task automatic step(input logic cap, input logic [31:0] val);
    int unsigned e;
    exp_t        x;
    capture_en = cap;
    io_out_in  = val;
    e = cyc + 1;
    if (!reset) begin
      mq.delete();
      next_free = 0;
      m_prev    = '0;
      m_ovf     = 1'b0;
    end else begin
      if (mq.size() > 0 && e >= next_free) begin
        x.word  = mq.pop_front();
        x.start = e;
        exp_q.push_back(x);
        next_free = e + W;
      end
      if (cap && val != m_prev) begin
        if (mq.size() < DEPTH) mq.push_back(val);
        else m_ovf = 1'b1;
      end
      m_prev = val;
    end
    m_busy = (e < next_free) || (mq.size() > 0);
    @(posedge clock);
    @(negedge clock);
    check("busy", {31'b0, busy}, {31'b0, m_busy});
    check("overflow", {31'b0, overflow}, {31'b0, m_ovf});
  endtask

  task automatic hold(input int unsigned n, input logic cap, input logic [31:0] val);
    for (int unsigned i = 0; i < n; i++) step(cap, val);
  endtask

  // Assert reset just after a negedge (mid-cycle) and check the immediate effect.
  task automatic do_reset(input logic [31:0] val);
    #1 reset = 1'b0;
    #1;
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    mq.delete();
    exp_q.delete();
    next_free = 0;
    m_prev    = '0;
    m_ovf     = 1'b0;
    m_busy    = 1'b0;
    @(negedge clock);
    hold(3, 1'b1, val);
    reset = 1'b1;
  endtask

  // Line monitor: decodes whole words by bit timing relative to the start edge.
  initial begin : monitor
    int unsigned s, target;
    logic [31:0] got;
    logic        have, aborted, frame_ok, par_ok;
    exp_t        ex;
    forever begin
      @(negedge clock);
      if (reset && tx == 1'b0) begin
        s          = cyc;
        mon_active = 1'b1;
        aborted    = 1'b0;
        frame_ok   = 1'b1;
        par_ok     = 1'b1;
        got        = '0;
        have       = (exp_q.size() > 0);
        ex         = '0;
        check("frame_expected", {31'b0, have}, 32'd1);
        if (have) begin
          ex = exp_q.pop_front();
          check("start_edge", s, ex.start);
        end
        for (int unsigned b = 0; b < 4; b++) begin
          for (int unsigned i = 0; i < F; i++) begin
            target = s + (b * F + i) * C + C / 2;
            while (!aborted && cyc < target) begin
              @(negedge clock);
              if (!reset) aborted = 1'b1;
            end
            if (!aborted) begin
              if (i == 0) frame_ok &= ~tx;
              else if (i <= 8) got[b*8+i-1] = tx;
`ifdef IO_OUT_UART_PARITY_EN
              else if (i == 9) par_ok &= (tx == ^got[b*8 +: 8]);
`endif
              else frame_ok &= tx;
            end
          end
        end
        if (!aborted) begin
          check("frame_bits", {31'b0, frame_ok}, 32'd1);
          check("parity", {31'b0, par_ok}, 32'd1);
          if (have) check("word", got, ex.word);
        end
        mon_active = 1'b0;
        while (!reset) @(negedge clock);
      end
    end
  end

  initial begin : stim
    logic [31:0] rv;
    int unsigned n;
    repeat (3) @(negedge clock);
    check("init_tx", {31'b0, tx}, 32'd1);
    check("init_busy", {31'b0, busy}, 32'd0);
    check("init_overflow", {31'b0, overflow}, 32'd0);
    reset = 1'b1;

    // Single word, latency and frame length.
    hold(3, 1'b1, 32'h0);
    step(1'b1, 32'h12345678);
    hold(W + 10, 1'b1, 32'h12345678);

    // Changes with capture disabled, then enabled with no change.
    hold(5, 1'b0, 32'hAA);
    hold(20, 1'b1, 32'hAA);

    // Six consecutive changes into a 4-deep FIFO.
    for (int unsigned v = 1; v <= 6; v++) step(1'b1, v);
    hold(5 * W + 20, 1'b1, 32'd6);

    // Two words 10 cycles apart chain without a gap.
    step(1'b1, 32'h11112222);
    hold(9, 1'b1, 32'h11112222);
    step(1'b1, 32'h33334444);
    hold(2 * W, 1'b1, 32'h33334444);

    // Parity-sensitive word.
    step(1'b1, 32'h00000007);
    hold(W + 20, 1'b1, 32'h00000007);

    // Reset in the middle of byte 2, then re-capture of the unchanged input.
    step(1'b1, 32'hCAFEF00D);
    hold(2 * F * C + 3 * C, 1'b1, 32'hCAFEF00D);
    do_reset(32'hCAFEF00D);
    hold(W + 20, 1'b1, 32'hCAFEF00D);

    // Randomized traffic with occasional bursts.
    rv = io_out_in;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        n = $urandom_range(2, 7);
        for (int unsigned k = 0; k < n; k++) begin
          rv = $urandom;
          step(1'b1, rv);
        end
      end else begin
        if ($urandom_range(0, 49) == 0) rv = $urandom;
        step($urandom_range(0, 7) != 0, rv);
      end
    end

    // Drain everything still queued or on the line.
    n = 0;
    while ((mq.size() != 0 || exp_q.size() != 0 || mon_active || m_busy) && n < 3000) begin
      step(1'b0, rv);
      n++;
    end
    check("drain_done", {31'b0, (n < 3000)}, 32'd1);
    check("idle_tx", {31'b0, tx}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_out_uart_tx.md
IO_OUT_UART_TX -- requirements
Module: io_out_uart_tx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 16, meaning clock cycles per UART bit (legal range 2..65535).
REQ-002 SHALL provide parameter FIFO_DEPTH, default 4, meaning number of 32-bit words buffered (power of two, 2..16).
REQ-003 SHALL provide port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL provide port reset, input, 1, asynchronous active-low reset (0 = in reset).
REQ-005 SHALL provide port io_out_in, input, 32, processor io_out word being monitored.
REQ-006 SHALL provide port capture_en, input, 1, enables change capture when 1.
REQ-007 SHALL provide port tx, output, 1, UART serial line, idle high.
REQ-008 SHALL provide port busy, output, 1, high when the FSM is not IDLE or the FIFO is non-empty.
REQ-009 SHALL provide port overflow, output, 1, sticky flag set when a captured word is dropped.

Function
REQ-010 SHALL register io_out_in into prev every cycle, regardless of capture_en.
REQ-011 SHALL push io_out_in into the FIFO at edge k when capture_en=1 and io_out_in != prev at edge k.
REQ-012 SHALL drop the push and set overflow=1 when the FIFO is full and no pop occurs in the same cycle.
REQ-013 SHALL accept both operations, without setting overflow, on simultaneous push and pop while full.
REQ-014 SHALL keep overflow at 1 until reset.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-016 SHALL, in IDLE with the FIFO non-empty, pop one word at the next edge, load the shift word, enter START and drive tx=0 from that edge.
REQ-017 SHALL give a one-cycle latency: a word pushed at edge k into an empty FIFO with the FSM in IDLE drives tx low after edge k+1.
REQ-018 SHALL hold each bit for exactly CLKS_PER_BIT cycles.
REQ-019 SHALL send DATA as 8 bits, LSB first.
REQ-020 SHALL send STOP as tx=1 for one bit time.
REQ-021 SHALL send the 4 bytes of a word back-to-back in order [7:0], [15:8], [23:16], [31:24], with no idle gap.
REQ-022 SHALL, after byte 3 STOP, pop the next word immediately into START when the FIFO is non-empty; otherwise it SHALL enter IDLE with tx=1.
REQ-023 SHALL skip the PARITY state unless the macro in REQ-029 is defined.
REQ-024 SHALL make one word take 4*10*CLKS_PER_BIT cycles, or 4*11*CLKS_PER_BIT with parity.
REQ-025 SHALL drive tx from a register with no combinational glitches.

Reset
REQ-026 SHALL, while reset=0, immediately force tx=1, busy=0, overflow=0, FSM=IDLE, FIFO empty, prev=0 and all bit/byte counters=0.
REQ-027 SHALL abort any frame in progress when reset is asserted mid-frame, with no completion of the partial byte.
REQ-028 SHALL treat the first capture after reset deassertion against prev=0, so a nonzero io_out_in with capture_en=1 is pushed.

Configuration
REQ-029 SHALL, with macro IO_OUT_UART_PARITY_EN defined, insert the PARITY state after DATA, sending even parity (XOR of the 8 data bits) for one bit time; without the macro, frames SHALL be 8N1 and no parity logic SHALL exist.

Verification
REQ-030 SHALL cover, with CLKS_PER_BIT=4 and io_out_in stepping 0 -> 0x12345678 with capture_en=1: tx low one cycle after push, bytes 0x78, 0x56, 0x34, 0x12 decoded, frame 160 cycles, then tx=1 and busy=0.
REQ-031 SHALL cover io_out_in changing on 6 consecutive cycles (values 1..6, FIFO_DEPTH=4): values 1..5 transmitted in order, 6 dropped, overflow=1 and held.
REQ-032 SHALL cover capture_en=0 while io_out_in changes 0 -> 0xAA: no frame, busy stays 0; then capture_en=1 with no change: still no frame.
REQ-033 SHALL cover reset=0 asserted mid-byte 2 of a word: tx=1 same cycle, busy=0, overflow=0; after release with unchanged nonzero input, the word is re-captured and sent whole.
REQ-034 SHALL cover, with IO_OUT_UART_PARITY_EN defined and word 0x00000007: byte 0x07 parity bit=1, bytes 0x00 parity bit=0, frame 176 cycles at CLKS_PER_BIT=4.
REQ-035 SHALL cover two words pushed 10 cycles apart: the second word's start bit immediately follows the first word's final stop bit, with no idle gap.
